// File: rtl/vga_pattern_ctrl.sv
// Test-pattern sequencer for the 1920x1080 VGA path: selects one of NUM_PATTERNS
// patterns and fades between them one step per frame, triggered by timer or req/ack.
module vga_pattern_ctrl #(
    parameter int unsigned NUM_PATTERNS = 4,
    parameter int unsigned HOLD_FRAMES  = 120,
    parameter int unsigned HDATA_BEGIN  = 191,
    parameter int unsigned VDATA_BEGIN  = 40,
    parameter int unsigned BAR_W        = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] hcount,
    input  logic [11:0] vcount,
    input  logic        data_act,
    input  logic        frame_start,
    input  logic        mode_auto,
    input  logic        step_req,
    output logic        step_ack,
    output logic        busy,
    output logic [2:0]  pattern_sel,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    typedef enum logic [1:0] {
        SHOW,
        FADE_OUT,
        SWITCH,
        FADE_IN
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic [4:0]        level_q, level_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              trigger;
    logic [11:0]       rgb_q, rgb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SHOW;
            sel_q   <= '0;
            level_q <= 5'd16;
            hold_q  <= '0;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            level_q <= level_d;
            hold_q  <= hold_d;
            rgb_q   <= rgb_d;
        end
    end

    // step_ack is combinational so the requester sees it on the accepting edge
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        level_d  = level_q;
        hold_d   = hold_q;
        trigger  = 1'b0;
        step_ack = 1'b0;
        case (state_q)
            SHOW: begin
                trigger = step_req ||
                          (mode_auto && frame_start && (hold_q == HOLD_W'(HOLD_FRAMES - 1)));
                if (!mode_auto) begin
                    hold_d = '0;
                end else if (frame_start) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                if (trigger) begin
                    state_d  = FADE_OUT;
                    hold_d   = '0;
                    step_ack = step_req;
                end
            end
            FADE_OUT: begin
                if (frame_start) begin
                    level_d = level_q - 5'd1;
                    if (level_q == 5'd1) begin
                        state_d = SWITCH;
                    end
                end
            end
            SWITCH: begin
                if (frame_start) begin
                    sel_d   = (sel_q == 3'(NUM_PATTERNS - 1)) ? '0 : sel_q + 3'd1;
                    state_d = FADE_IN;
                end
            end
            FADE_IN: begin
                if (frame_start) begin
                    level_d = level_q + 5'd1;
                    if (level_q == 5'd15) begin
                        state_d = SHOW;
                        hold_d  = '0;
                    end
                end
            end
            default: state_d = SHOW;
        endcase
    end

    assign busy        = (state_q != SHOW);
    assign pattern_sel = sel_q;

    logic [11:0] x, y;
    logic [2:0]  bar;
    logic [11:0] c;
    logic        unused_y_bits;

    assign x             = hcount - 12'(HDATA_BEGIN);
    assign y             = vcount - 12'(VDATA_BEGIN);
    assign unused_y_bits = ^{y[11:10], y[5:0]};

    function automatic logic [3:0] fade(input logic [3:0] ch, input logic [4:0] lv);
        logic [8:0] p;
        p = {5'b0, ch} * {4'b0, lv};
        return 4'(p >> 4);
    endfunction

    always_comb begin
        bar = (x >= 12'(7 * BAR_W)) ? 3'd7 : 3'(x / 12'(BAR_W));
        c   = '0;
        case (sel_q)
            3'd0: begin
                case (bar)
                    3'd0:    c = 12'hFFF;
                    3'd1:    c = 12'h049;
                    3'd2:    c = 12'h22E;
                    3'd3:    c = 12'h83B;
                    3'd4:    c = 12'h444;
                    3'd5:    c = 12'h555;
                    3'd6:    c = 12'h620;
                    default: c = 12'h8F0;
                endcase
            end
            3'd1:    c = (x[6] ^ y[6]) ? 12'hFFF : 12'h000;
            3'd2:    c = {x[10:7], y[9:6], 4'h0};
            3'd3:    c = 12'h888;
            default: c = '0;
        endcase
        rgb_d = '0;
        if (data_act) begin
            rgb_d = {fade(c[11:8], level_q), fade(c[7:4], level_q), fade(c[3:0], level_q)};
        end
    end

    assign red   = rgb_q[11:8];
    assign green = rgb_q[7:4];
    assign blue  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// Bench for vga_pattern_ctrl: pixel vectors through a scoreboard queue plus
// hand-written fade, handshake, auto-cycle and reset sequences.
module tb_vga_pattern_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] hcount, vcount;
    logic        data_act, frame_start, mode_auto, step_req;
    logic        step_ack, busy;
    logic [2:0]  pattern_sel;
    logic [3:0]  red, green, blue;

    vga_pattern_ctrl #(
        .NUM_PATTERNS(4),
        .HOLD_FRAMES (3),
        .HDATA_BEGIN (191),
        .VDATA_BEGIN (40),
        .BAR_W       (240)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hcount     (hcount),
        .vcount     (vcount),
        .data_act   (data_act),
        .frame_start(frame_start),
        .mode_auto  (mode_auto),
        .step_req   (step_req),
        .step_ack   (step_ack),
        .busy       (busy),
        .pattern_sel(pattern_sel),
        .red        (red),
        .green      (green),
        .blue       (blue)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned sel;
        logic [11:0] h;
        logic [11:0] v;
        logic        act;
        logic [11:0] rgb;
    } vec_t;

    vec_t        tbl[16];
    logic [11:0] sb_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned sel_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
    endtask

    task automatic pix(input logic [11:0] h, input logic [11:0] v, input logic act,
                       input logic [11:0] exp);
        logic [11:0] want;
        hcount   = h;
        vcount   = v;
        data_act = act;
        sb_q.push_back(exp);
        tick();
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: queue empty at t=%0t", $time);
        end else begin
            want = sb_q.pop_front();
            check("rgb", {20'd0, red, green, blue}, {20'd0, want});
        end
    endtask

    task automatic req_accept();
        step_req = 1'b1;
        #1;
        check("ack_on_req", step_ack, 1);
        check("busy_before_accept", busy, 0);
        tick();
        step_req = 1'b0;
        check("ack_one_cycle", step_ack, 0);
        check("busy_after_accept", busy, 1);
    endtask

    task automatic run_switch();
        int unsigned old;
        old = sel_exp;
        frames(16);
        check("sel_hold_at_level0", pattern_sel, old);
        check("busy_switch", busy, 1);
        frames(1);
        sel_exp = (old == 3) ? 0 : old + 1;
        check("sel_step", pattern_sel, sel_exp);
        check("busy_fade_in", busy, 1);
        frames(15);
        check("busy_frame32", busy, 1);
        frames(1);
        check("busy_frame33", busy, 0);
        check("sel_final", pattern_sel, sel_exp);
    endtask

    initial begin
        tbl[0]  = '{0, 12'd191,  12'd40,  1'b1, 12'hFFF};
        tbl[1]  = '{0, 12'd431,  12'd40,  1'b1, 12'h049};
        tbl[2]  = '{0, 12'd911,  12'd40,  1'b1, 12'h83B};
        tbl[3]  = '{0, 12'd1151, 12'd40,  1'b1, 12'h444};
        tbl[4]  = '{0, 12'd1631, 12'd40,  1'b1, 12'h620};
        tbl[5]  = '{0, 12'd1871, 12'd40,  1'b1, 12'h8F0};
        tbl[6]  = '{0, 12'd2100, 12'd40,  1'b1, 12'h8F0};
        tbl[7]  = '{0, 12'd1871, 12'd40,  1'b0, 12'h000};
        tbl[8]  = '{1, 12'd191,  12'd40,  1'b1, 12'h000};
        tbl[9]  = '{1, 12'd255,  12'd40,  1'b1, 12'hFFF};
        tbl[10] = '{1, 12'd255,  12'd104, 1'b1, 12'h000};
        tbl[11] = '{1, 12'd191,  12'd104, 1'b1, 12'hFFF};
        tbl[12] = '{2, 12'd191,  12'd40,  1'b1, 12'h000};
        tbl[13] = '{2, 12'd319,  12'd104, 1'b1, 12'h110};
        tbl[14] = '{2, 12'd1471, 12'd680, 1'b1, 12'hAA0};
        tbl[15] = '{2, 12'd1471, 12'd680, 1'b0, 12'h000};

        rst_n       = 1'b0;
        hcount      = '0;
        vcount      = '0;
        data_act    = 1'b0;
        frame_start = 1'b0;
        mode_auto   = 1'b0;
        step_req    = 1'b0;
        sel_exp     = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sel", pattern_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", step_ack, 0);
        check("rst_rgb", {red, green, blue}, 0);
        rst_n = 1'b1;
        tick();

        // Pixel vectors; a manual switch is run whenever the table moves to the next pattern
        for (int unsigned i = 0; i < 16; i++) begin
            if (tbl[i].sel != sel_exp) begin
                req_accept();
                run_switch();
            end
            pix(tbl[i].h, tbl[i].v, tbl[i].act, tbl[i].rgb);
        end

        // 2 -> 3: fade-in levels, then a request parked during FADE_IN
        req_accept();
        frames(16);
        check("sel_before_switch", pattern_sel, 2);
        frames(1);
        sel_exp = 3;
        check("sel_to_3", pattern_sel, 3);
        frames(1);
        pix(12'd191, 12'd40, 1'b1, 12'h000);
        frames(7);
        pix(12'd191, 12'd40, 1'b1, 12'h444);
        step_req = 1'b1;
        #1;
        check("no_ack_in_fade_in", step_ack, 0);
        frames(7);
        check("no_ack_level15", step_ack, 0);
        check("busy_level15", busy, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("ack_first_show", step_ack, 1);
        check("busy_first_show", busy, 0);
        tick();
        step_req = 1'b0;
        check("ack_dropped", step_ack, 0);
        check("busy_reaccepted", busy, 1);
        pix(12'd191, 12'd40, 1'b1, 12'h888);
        run_switch();

        // Auto and manual trigger on the same frame_start: one switch, one ack
        mode_auto = 1'b1;
        frames(2);
        check("busy_auto_hold", busy, 0);
        frame_start = 1'b1;
        step_req    = 1'b1;
        #1;
        check("ack_simultaneous", step_ack, 1);
        tick();
        frame_start = 1'b0;
        step_req    = 1'b0;
        check("ack_simul_once", step_ack, 0);
        check("busy_simul", busy, 1);
        run_switch();

        // Timed cycling 1 -> 2 -> 3 -> 0; auto dropped mid-fade on the last one
        for (int unsigned k = 0; k < 3; k++) begin
            frames(2);
            check("busy_auto_wait", busy, 0);
            frame_start = 1'b1;
            #1;
            check("ack_auto", step_ack, 0);
            tick();
            frame_start = 1'b0;
            check("busy_auto_trig", busy, 1);
            if (k == 2) mode_auto = 1'b0;
            run_switch();
        end

        // Reset in the middle of FADE_OUT at level 5
        req_accept();
        run_switch();
        req_accept();
        frames(11);
        pix(12'd255, 12'd40, 1'b1, 12'h444);
        rst_n = 1'b0;
        #1;
        check("async_rst_sel", pattern_sel, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_rgb", {red, green, blue}, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        sel_exp = 0;
        pix(12'd191, 12'd40, 1'b1, 12'hFFF);
        check("post_rst_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_pattern_ctrl.md
Name: vga_pattern_ctrl

Overview:
- Display-sequencing controller between the 1920x1080 VGA timing generator and the colour pins.
- Takes the timing generator's counters and strobes, and selects one of NUM_PATTERNS test patterns.
- Switches patterns only at frame boundaries, with a frame-stepped fade-out/fade-in.
- Switching is triggered either automatically after HOLD_FRAMES frames or by a req/ack step handshake from the button/UI logic.

Parameters:
- NUM_PATTERNS, 4: number of patterns; sel wraps NUM_PATTERNS-1 -> 0.
- HOLD_FRAMES, 120: frames a pattern is shown in auto mode before switching; must be >= 1.
- HDATA_BEGIN, 191: first active hcount.
- VDATA_BEGIN, 40: first active vcount.
- BAR_W, 240: colour-bar width in pixels.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hcount  in  12  horizontal counter from timing generator
- vcount  in  12  vertical counter from timing generator
- data_act  in  1  high inside the visible area
- frame_start  in  1  1-cycle pulse at the start of each frame (vcount wrap)
- mode_auto  in  1  1 = timed auto-cycling, 0 = manual only
- step_req  in  1  level request to advance pattern; held until ack
- step_ack  out  1  1-cycle pulse when step_req is accepted
- busy  out  1  high in any state other than SHOW
- pattern_sel  out  3  current pattern index
- red  out  4  colour out, registered
- green  out  4  colour out, registered
- blue  out  4  colour out, registered

Behaviour:
- Reset (async, rst_n=0) values: state=SHOW, pattern_sel=0, level=16 (5-bit), hold_cnt=0, step_ack=0, busy=0, red/green/blue=0.
- FSM state SHOW (level=16):
  - hold_cnt increments on each frame_start while mode_auto=1; it is cleared while mode_auto=0 and on entry to SHOW.
  - Trigger condition: step_req=1, or (mode_auto=1 and frame_start and hold_cnt==HOLD_FRAMES-1).
  - On trigger: go to FADE_OUT. If step_req=1, pulse step_ack for exactly that cycle.
  - Simultaneous auto and manual trigger produce a single transition with step_ack asserted.
- FSM state FADE_OUT: level -= 1 on each frame_start; when level reaches 0, go to SWITCH.
- FSM state SWITCH:
  - On the next frame_start: pattern_sel <= (pattern_sel==NUM_PATTERNS-1) ? 0 : pattern_sel+1, then go to FADE_IN.
  - Output is black for this whole frame.
- FSM state FADE_IN: level += 1 on each frame_start; when level reaches 16, go to SHOW.
- Full switch cost: 16 + 1 + 16 = 33 frame_starts.
- step_req outside SHOW is not accepted; no ack is given and the request stays pending until SHOW.
- mode_auto changes mid-fade do not abort the sequence.
- Pattern colour c is computed from x = hcount-HDATA_BEGIN and y = vcount-VDATA_BEGIN, 12-bit unsigned.
  - Pattern 0, 8 colour bars of BAR_W, bar index = x/BAR_W clamped to 7. RGB per bar, in order: FFF, 049, 22E, 83B, 444, 555, 620, 8F0.
  - Pattern 1, 64x64 checker: white when x[6]^y[6], else black.
  - Pattern 2, gradient: red = x[10:7], green = y[9:6], blue = 0.
  - Pattern 3, solid grey: 888.
- Fade arithmetic: out = (c * level) >> 4 per channel. The 4b x 5b product is 9 bits; take bits [7:4]. level=16 yields c exactly; level=0 yields 0.
- Output latency: red/green/blue are registered with 1 clk latency from hcount/vcount/data_act. When the registered data_act=0, outputs are 0.
- Reset asserted mid-fade aborts immediately to the reset values.

Test Plan:
- Reset, mode_auto=0, data_act=1, pattern 0: hcount=191 -> RGB=FFF one clk later; hcount=431 -> 049; hcount=1871 -> 8F0. With data_act=0 -> 000.
- Manual step, HOLD_FRAMES irrelevant: raise step_req in SHOW -> step_ack pulse of 1 clk, busy=1. Then 16 frame_starts reach level 0 and the 17th switches pattern_sel 0->1. busy falls after 33 frame_starts total.
- Auto mode, HOLD_FRAMES=3: after the 3rd frame_start in SHOW -> FADE_OUT entered, step_ack stays 0, and pattern_sel steps 0->1->2->3->0 across successive cycles (wrap check).
- step_req raised during FADE_IN -> no ack until SHOW is re-entered, then ack on the first SHOW cycle while req is still high. Same-cycle auto and manual trigger -> one switch, one ack.
- Fade math: pattern 3 with level=8 -> RGB=444; level=1 -> 000; level=16 -> 888.
- Assert rst_n low mid-FADE_OUT at level 5 -> asynchronously pattern_sel=0, level=16, RGB=000, busy=0.
